// File: rtl/fht_adc_loader.sv
// Streams ADC samples into the four interleaved FHT input banks, starts the
// transform once a full frame is loaded and waits for it to finish.
module fht_adc_loader #(
    parameter int D_BIT = 16,
    parameter int A_BIT = 8
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iEN,
    input  logic             iVALID,
    input  logic [D_BIT-2:0] iSAMPLE,
    output logic             oREADY,
    input  logic             iFHT_RDY,
    output logic [3:0]       oWE,
    output logic [D_BIT-2:0] oDATA,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic             oSTART,
    output logic             oFRAME_DONE,
    output logic [15:0]      oDROP_CNT
);

    localparam int K_BIT = A_BIT + 2;

    typedef enum logic [2:0] {
        FILL,
        LAST,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state_reg;
    logic [K_BIT-1:0]   k_reg;
    logic [3:0]         we_reg;
    logic [D_BIT-2:0]   data_reg;
    logic [A_BIT-1:0]   addr_reg;
    logic               start_reg;
    logic               done_reg;
    logic [15:0]        drop_reg;

    logic               ready;
    logic               accept;
    logic               drop;
    logic [3:0]         we_next;

    // Sample k lands in bank k[1:0]; the bank decode is one-hot.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank_sel
        assign we_next[gi] = (k_reg[1:0] == 2'(gi));
    end

    // Ready is gated by reset so nothing is accepted on the reset edge.
    assign ready  = (state_reg == FILL) && iEN && !iRESET;
    assign accept = iVALID && ready;
    // With capture disabled a missed sample is intentional, not a drop.
    assign drop   = iVALID && iEN && (state_reg != FILL);

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_reg <= FILL;
            k_reg     <= '0;
            we_reg    <= '0;
            data_reg  <= '0;
            addr_reg  <= '0;
            start_reg <= 1'b0;
            done_reg  <= 1'b0;
            drop_reg  <= '0;
        end else begin
            we_reg    <= '0;
            start_reg <= 1'b0;
            done_reg  <= 1'b0;

            if (drop && (drop_reg != 16'hFFFF)) begin
                drop_reg <= drop_reg + 16'd1;
            end

            case (state_reg)
                FILL: begin
                    if (accept) begin
                        data_reg <= iSAMPLE;
                        we_reg   <= we_next;
                        addr_reg <= k_reg[K_BIT-1:2];
                        k_reg    <= k_reg + K_BIT'(1);
                        if (k_reg == '1) begin
                            state_reg <= LAST;
                        end
                    end
                end
                LAST: begin
                    start_reg <= 1'b1;
                    state_reg <= START;
                end
                START: begin
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!iFHT_RDY) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (iFHT_RDY) begin
                        done_reg  <= 1'b1;
                        k_reg     <= '0;
                        state_reg <= FILL;
                    end
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase
        end
    end

    assign oREADY      = ready;
    assign oWE         = we_reg;
    assign oDATA       = data_reg;
    assign oADDR_WR    = addr_reg;
    assign oSTART      = start_reg;
    assign oFRAME_DONE = done_reg;
    assign oDROP_CNT   = drop_reg;

endmodule

// File: tb/tb_fht_adc_loader.sv
// Directed bench for fht_adc_loader with a 16-sample frame (A_BIT=2).
module tb_fht_adc_loader;

    localparam int D_BIT = 16;
    localparam int A_BIT = 2;

    logic             clk = 1'b0;
    logic             srst;
    logic             en;
    logic             valid;
    logic [D_BIT-2:0] sample;
    logic             ready;
    logic             fht_rdy;
    logic [3:0]       we;
    logic [D_BIT-2:0] data;
    logic [A_BIT-1:0] addr;
    logic             start;
    logic             frame_done;
    logic [15:0]      drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fht_adc_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
        .iCLK        (clk),
        .iRESET      (srst),
        .iEN         (en),
        .iVALID      (valid),
        .iSAMPLE     (sample),
        .oREADY      (ready),
        .iFHT_RDY    (fht_rdy),
        .oWE         (we),
        .oDATA       (data),
        .oADDR_WR    (addr),
        .oSTART      (start),
        .oFRAME_DONE (frame_done),
        .oDROP_CNT   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers samples k=first..last (base+k) back to back and checks the bank write.
    task automatic feed(input int first, input int last, input int base);
        for (int k = first; k <= last; k++) begin
            en     = 1'b1;
            valid  = 1'b1;
            sample = 15'(base + k);
            step();
            $display("sample k=%0d data=%0d we=%b addr=%0d drops=%0d", k, data, we, addr, drop_cnt);
            check_eq("we", 32'(we), 32'(4'b0001 << (k % 4)));
            check_eq("addr", 32'(addr), 32'(k / 4));
            check_eq("data", 32'(data), 32'(base + k));
        end
    endtask

    // Entered in the START cycle; wait cycles seen by the loader = n_hi + n_lo.
    task automatic handshake(input int n_hi, input int n_lo);
        for (int i = 0; i < n_hi; i++) begin
            fht_rdy = 1'b1;
            step();
            check_eq("done_early_hi", 32'(frame_done), 32'd0);
        end
        for (int i = 0; i < n_lo; i++) begin
            fht_rdy = 1'b0;
            step();
            check_eq("done_early_lo", 32'(frame_done), 32'd0);
        end
        fht_rdy = 1'b1;
        step();
        $display("frame done pulse=%0d drops=%0d", frame_done, drop_cnt);
        check_eq("frame_done", 32'(frame_done), 32'd1);
        check_eq("ready_after_done", 32'(ready), 32'd1);
    endtask

    // Called in the LAST cycle: no more accepts, then one start pulse.
    task automatic expect_start();
        check_eq("ready_last", 32'(ready), 32'd0);
        check_eq("start_last", 32'(start), 32'd0);
        step();
        check_eq("start", 32'(start), 32'd1);
        check_eq("we_start", 32'(we), 32'd0);
    endtask

    task automatic do_reset();
        srst  = 1'b1;
        valid = 1'b0;
        step();
        srst = 1'b0;
    endtask

    initial begin
        srst    = 1'b1;
        en      = 1'b1;
        valid   = 1'b1;
        sample  = 15'h7fff;
        fht_rdy = 1'b1;

        // Reset state, with enable and valid high to prove reset dominates
        step();
        step();
        $display("reset: we=%b data=%0d addr=%0d ready=%0d", we, data, addr, ready);
        check_eq("rst_we", 32'(we), 32'd0);
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_start", 32'(start), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        srst = 1'b0;
        #1;
        check_eq("ready_after_rst", 32'(ready), 32'd1);

        // Full frame and FHT handshake; valid stays high: 2 + 25 drops
        feed(0, 15, 0);
        expect_start();
        handshake(5, 20);
        check_eq("drops_frame1", 32'(drop_cnt), 32'd27);
        feed(0, 0, 200);
        check_eq("done_once", 32'(frame_done), 32'd0);

        // Pause mid-frame with capture disabled
        do_reset();
        feed(0, 6, 100);
        en    = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("ready_paused", 32'(ready), 32'd0);
            step();
            check_eq("we_paused", 32'(we), 32'd0);
        end
        check_eq("data_hold", 32'(data), 32'd106);
        check_eq("addr_hold", 32'(addr), 32'd1);
        feed(7, 15, 100);
        check_eq("drops_pause", 32'(drop_cnt), 32'd0);
        expect_start();
        handshake(10, 30);
        check_eq("drops_42", 32'(drop_cnt), 32'd42);

        // Saturation of the drop counter while the FHT stays busy
        do_reset();
        feed(0, 15, 300);
        expect_start();
        fht_rdy = 1'b1;
        valid   = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        $display("saturation: drops=0x%0h", drop_cnt);
        check_eq("drops_sat", 32'(drop_cnt), 32'h0000FFFF);

        // Reset mid-frame after sample 9
        do_reset();
        feed(0, 9, 400);
        srst  = 1'b1;
        valid = 1'b1;
        step();
        $display("mid-frame reset: we=%b data=%0d addr=%0d", we, data, addr);
        check_eq("mrst_we", 32'(we), 32'd0);
        check_eq("mrst_data", 32'(data), 32'd0);
        check_eq("mrst_addr", 32'(addr), 32'd0);
        check_eq("mrst_drop", 32'(drop_cnt), 32'd0);
        check_eq("mrst_ready", 32'(ready), 32'd0);
        srst = 1'b0;
        feed(0, 0, 500);
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("mrst_no_start", 32'(start), 32'd0);
        end

        // Reset while waiting for the FHT to finish
        do_reset();
        feed(0, 15, 600);
        expect_start();
        fht_rdy = 1'b0;
        step();
        step();
        srst    = 1'b1;
        fht_rdy = 1'b1;
        step();
        check_eq("wdrst_done", 32'(frame_done), 32'd0);
        srst = 1'b0;
        #1;
        $display("wait-done reset released: ready=%0d", ready);
        check_eq("wdrst_ready", 32'(ready), 32'd1);
        valid = 1'b0;
        step();
        check_eq("wdrst_no_done", 32'(frame_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
